// File: rtl/imem_loader.sv
// Boot-time instruction loader: length-prefixed byte stream -> little-endian 32-bit imem writes.
// Holds the rv32i core in reset until a complete, legal image has been written.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN0  = 3'd1;
    localparam logic [2:0] LEN1  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    logic [2:0]        state, stateNext;
    logic [15:0]       len, lenNext;
    logic [1:0]        byteCnt, byteCntNext;
    logic [ADDR_W-1:0] wordAddr, wordAddrNext;
    logic [31:0]       shreg, shregNext;
    logic [ADDR_W-1:0] addrNext;
    logic [31:0]       wdataNext;
    logic [15:0]       lenFull;
    logic              accept;
    logic              rxReadyNext, weNext, coreRstNext, busyNext, doneNext, errNext;

    // Next-state and registered-output decode; outputs are decoded from the next state
    // so every output is a flop that tracks the current state.
    always_comb begin
        stateNext    = state;
        lenNext      = len;
        byteCntNext  = byteCnt;
        wordAddrNext = wordAddr;
        shregNext    = shreg;
        addrNext     = imem_addr;
        wdataNext    = imem_wdata;
        lenFull      = {rx_data, len[7:0]};
        accept       = rx_valid & rx_ready;

        case (state)
            IDLE: begin
                if (start) stateNext = LEN0;
            end
            LEN0: begin
                if (accept) begin
                    lenNext[7:0] = rx_data;
                    stateNext    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    lenNext[15:8] = rx_data;
                    // 17-bit compare so a full 65536-word memory stays legal
                    if (lenFull == 16'd0 || 17'(lenFull) > 17'(DEPTH)) begin
                        stateNext = ERR;
                    end else begin
                        stateNext    = DATA;
                        byteCntNext  = 2'd0;
                        wordAddrNext = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shregNext[{byteCnt, 3'b000} +: 8] = rx_data;
                    byteCntNext = byteCnt + 2'd1;
                    if (byteCnt == 2'd3) begin
                        stateNext = WRITE;
                        addrNext  = wordAddr;
                        wdataNext = shregNext;
                    end
                end
            end
            WRITE: begin
                wordAddrNext = wordAddr + ADDR_W'(1);
                if (17'(wordAddr) + 17'd1 == 17'(len)) stateNext = DONE;
                else                                   stateNext = DATA;
            end
            DONE, ERR: begin
                if (start) stateNext = LEN0;
            end
            default: stateNext = IDLE;
        endcase

        rxReadyNext = (stateNext == LEN0) || (stateNext == LEN1) || (stateNext == DATA);
        weNext      = (stateNext == WRITE);
        coreRstNext = (stateNext != DONE);
        busyNext    = rxReadyNext || (stateNext == WRITE);
        doneNext    = (stateNext == DONE);
        errNext     = (stateNext == ERR);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            byteCnt    <= '0;
            wordAddr   <= '0;
            shreg      <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= stateNext;
            len        <= lenNext;
            byteCnt    <= byteCntNext;
            wordAddr   <= wordAddrNext;
            shreg      <= shregNext;
            rx_ready   <= rxReadyNext;
            imem_we    <= weNext;
            imem_addr  <= addrNext;
            imem_wdata <= wdataNext;
            core_rst   <= coreRstNext;
            busy       <= busyNext;
            done       <= doneNext;
            err        <= errNext;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected imem writes are queued as bytes are issued,
// and a negedge monitor pops and compares every imem_we it sees.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  expAddr[$];
    logic [31:0] expData[$];

    imem_loader #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("ready_low_in_write", 32'(rx_ready), 32'd0);
            checks++;
            if (expAddr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_we: got addr 0x%02h data 0x%08h expected no write at %0t",
                         imem_addr, imem_wdata, $time);
            end else begin
                logic [7:0]  ea;
                logic [31:0] ed;
                ea = expAddr.pop_front();
                ed = expData.pop_front();
                if (imem_addr !== ea || imem_wdata !== ed) begin
                    failures++;
                    $display("FAIL write: got addr 0x%02h data 0x%08h expected addr 0x%02h data 0x%08h",
                             imem_addr, imem_wdata, ea, ed);
                end
            end
        end
    end

    // Drive one byte with an optional idle gap; returns one cycle after acceptance + #1
    task automatic sendByte(input logic [7:0] b, input int gap);
        int guard;
        bit got;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        got      = 1'b0;
        while (!got && guard < 200) begin
            @(negedge clk);
            if (rx_ready === 1'b1) got = 1'b1;
            else guard++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL byte_accept_timeout: got no rx_ready expected accept of 0x%02h", b);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendImage(input int n, input logic [31:0] w0, input logic [31:0] w1,
                             input int maxGap, input int startAt);
        logic [15:0] lenV;
        logic [31:0] w;
        lenV = 16'(n);
        sendByte(lenV[7:0], 0);
        sendByte(lenV[15:8], 0);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            expAddr.push_back(8'(i));
            expData.push_back(w);
            for (int k = 0; k < 4; k++) begin
                if (k + 4 * i == startAt) start = 1'b1;
                sendByte(w[8*k +: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
                start = 1'b0;
            end
        end
    endtask

    task automatic waitStatus(input string name, input bit wantDone);
        int guard;
        guard = 0;
        @(negedge clk);
        while (done !== 1'b1 && err !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_done"}, 32'(done), 32'(wantDone));
        chk({name, "_err"}, 32'(err), 32'(!wantDone));
        chk({name, "_core_rst"}, 32'(core_rst), 32'(!wantDone));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string name);
        @(negedge clk);
        chk({name, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_we"}, 32'(imem_we), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: reset while idle
        #1 rst = 1'b1;
        checkIdle("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        checkIdle("after_reset");
        @(posedge clk);
        #1;

        // 2: two-word image, back-to-back bytes
        pulseStart();
        sendImage(2, 32'h00A0_0513, 32'h00B0_0593, 0, -1);
        waitStatus("img2", 1'b1);
        chk("img2_queue_empty", 32'(expAddr.size()), 32'd0);

        // 3: same image with random valid gaps, started from DONE
        pulseStart();
        sendImage(2, 32'h00A0_0513, 32'h00B0_0593, 3, -1);
        waitStatus("img3", 1'b1);
        chk("img3_queue_empty", 32'(expAddr.size()), 32'd0);

        // 4: zero length, then oversize length, then recovery
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        waitStatus("len0", 1'b0);
        pulseStart();
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        waitStatus("len257", 1'b0);
        pulseStart();
        sendImage(1, 32'h1234_5678, 32'h0, 0, -1);
        waitStatus("recover", 1'b1);
        chk("recover_queue_empty", 32'(expAddr.size()), 32'd0);

        // 5: reset after the 6th data byte
        pulseStart();
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        expAddr.push_back(8'h00);
        expData.push_back(32'hDEAD_BEEF);
        sendByte(8'hEF, 0);
        sendByte(8'hBE, 0);
        sendByte(8'hAD, 0);
        sendByte(8'hDE, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        rst = 1'b1;
        checkIdle("midload_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_reset_no_ready", 32'(rx_ready), 32'd0);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
        chk("midload_queue_empty", 32'(expAddr.size()), 32'd0);

        // 6: start ignored during DATA, start in DONE restarts
        pulseStart();
        sendImage(2, 32'hCAFE_F00D, 32'h0102_0304, 0, 2);
        waitStatus("start_in_data", 1'b1);
        chk("start_in_data_queue_empty", 32'(expAddr.size()), 32'd0);
        pulseStart();
        @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_core_rst", 32'(core_rst), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        sendImage(1, 32'h0000_0073, 32'h0, 0, -1);
        waitStatus("final", 1'b1);
        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(expAddr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
